// File: rtl/freq_ratio_ramp_if.sv
// freq_ratio_ramp_if
//   Bundles the target request, divider update handshake and status signals
//   of freq_ratio_ramp. Clock and reset are plain ports on the module.
//
//   slave  : the ramp sequencer (freq_ratio_ramp)
//   master : whoever supplies targets and acknowledges ratio updates
//
//   Signals:
//     tgt_ratio[9:0], tgt_vld, tgt_rdy : target request (valid/ready)
//     step[4:0]                        : maximum ratio change per step
//     ratio[9:0]                       : ratio presented to the divider
//     ratio_upd_req, ratio_upd_ack     : 4-phase update handshake
//     busy, done, err                  : status
//     state_dbg[1:0]                   : current FSM state
interface freq_ratio_ramp_if;
    logic [9:0] tgt_ratio;
    logic       tgt_vld;
    logic       tgt_rdy;
    logic [4:0] step;
    logic [9:0] ratio;
    logic       ratio_upd_req;
    logic       ratio_upd_ack;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] state_dbg;

    modport slave (
        input  tgt_ratio, tgt_vld, step, ratio_upd_ack,
        output tgt_rdy, ratio, ratio_upd_req, busy, done, err, state_dbg
    );

    modport master (
        output tgt_ratio, tgt_vld, step, ratio_upd_ack,
        input  tgt_rdy, ratio, ratio_upd_req, busy, done, err, state_dbg
    );
endinterface

// File: rtl/freq_ratio_ramp.sv
// freq_ratio_ramp
//   Walks the divider ratio from its current value to a requested target in
//   bounded steps. Every step is a full 4-phase req/ack handshake followed by
//   a dwell of DWELL clkin cycles, so consumers never see a large jump.
//
//   Ports:
//     clkin : divider input clock (sole clock)
//     rstb  : asynchronous active-low reset
//     bus   : freq_ratio_ramp_if.slave (target, handshake, status, state_dbg)
//
//   Handshakes:
//     Target: a target transfers on a rising clkin edge where tgt_vld and
//     tgt_rdy are both high. tgt_rdy is high only in IDLE, with no target
//     pending evaluation and ratio_upd_ack low. tgt_vld outside that window
//     is ignored (no queueing).
//     Divider: 4-phase. req rises together with the new ratio; ratio holds
//     until the divider has acknowledged and released ack.
//
//   Optional feature: define FREQ_RAMP_TIMEOUT_EN to abort a handshake that
//   has not completed within ACK_TIMEOUT cycles (err becomes sticky until
//   the next accepted target). Without it err is tied low.
module freq_ratio_ramp #(
    parameter logic [9:0] RESET_RATIO = 10'd2,
    parameter int         DWELL       = 16,
    parameter int         ACK_TIMEOUT = 1024
) (
    input  logic               clkin,
    input  logic               rstb,
    freq_ratio_ramp_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACKLO, S_DWELL} state_t;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

    if (DWELL < 0 || DWELL > 65536 || ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65536) begin : g_param_check
        $error("freq_ratio_ramp: DWELL or ACK_TIMEOUT out of range");
    end

    state_t      state_q, state_d;
    logic [9:0]  cur_q, cur_d;
    logic [9:0]  tgt_q;
    logic [4:0]  step_q;
    logic [15:0] cnt_q, cnt_d;
    logic        pend_q;   // target latched last edge, compared against cur now
    logic        ack_q;    // ack as sampled on the previous edge
    logic        done_q, done_d;
    logic        accept;
    logic        to_hit;
    logic [9:0]  diff, step_ext, sdelta, nxt;

    assign bus.tgt_rdy       = (state_q == S_IDLE) && !pend_q && !bus.ratio_upd_ack;
    assign accept            = bus.tgt_vld && bus.tgt_rdy;
    assign bus.ratio         = cur_q;
    assign bus.ratio_upd_req = (state_q == S_REQ);
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = done_q;
    assign bus.state_dbg     = state_q;

    // Next ratio: move toward tgt by at most step_q (0 = whole distance).
    // cur never overshoots tgt, so the 10-bit arithmetic cannot wrap.
    always_comb begin
        diff     = (tgt_q > cur_q) ? (tgt_q - cur_q) : (cur_q - tgt_q);
        step_ext = {5'd0, step_q};
        sdelta   = (step_q == 5'd0 || step_ext > diff) ? diff : step_ext;
        nxt      = (tgt_q > cur_q) ? (cur_q + sdelta) : (cur_q - sdelta);
    end

`ifdef FREQ_RAMP_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);
    logic err_q;

    assign to_hit  = (state_q == S_REQ || state_q == S_ACKLO) && (cnt_q >= TO_LAST);
    assign bus.err = err_q;

    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb)       err_q <= 1'b0;
        else if (accept) err_q <= 1'b0;
        else if (to_hit) err_q <= 1'b1;
    end
`else
    assign to_hit  = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (to_hit) begin
            // Abandon the handshake; ratio keeps the last value sent.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pend_q) begin
                        if (tgt_q == cur_q) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = S_REQ;
                            cur_d   = nxt;
                            cnt_d   = 16'd0;
                        end
                    end
                end
                S_REQ: begin
`ifdef FREQ_RAMP_TIMEOUT_EN
                    cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`endif
                    if (ack_q) state_d = S_ACKLO;
                end
                S_ACKLO: begin
`ifdef FREQ_RAMP_TIMEOUT_EN
                    cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`endif
                    if (!ack_q) begin
                        if (DWELL == 0) begin
                            if (cur_q == tgt_q) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = S_REQ;
                                cur_d   = nxt;
                                cnt_d   = 16'd0;
                            end
                        end else begin
                            state_d = S_DWELL;
                            cnt_d   = 16'd0;
                        end
                    end
                end
                S_DWELL: begin
                    if (cnt_q == DWELL_LAST) begin
                        if (cur_q == tgt_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_REQ;
                            cur_d   = nxt;
                            cnt_d   = 16'd0;
                        end
                    end else begin
                        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            cur_q   <= RESET_RATIO;
            tgt_q   <= RESET_RATIO;
            step_q  <= 5'd0;
            cnt_q   <= 16'd0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            pend_q  <= accept;
            ack_q   <= bus.ratio_upd_ack;
            done_q  <= done_d;
            if (accept) begin
                tgt_q  <= (bus.tgt_ratio == 10'd0) ? 10'd1 : bus.tgt_ratio;
                step_q <= bus.step;
            end
        end
    end
endmodule
